// File: rtl/keypad_timer.sv
// Microwave cook timer: BCD key entry into MM:SS, 1 s countdown,
// pause on door/cancel, one-cycle done pulse on expiry.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   key_bcd, key_dv  encoder digit and active-low valid flag
//   start, cancel    start/resume request, pause/clear request
//   door_open        1 = door open
//   key_en_n         encoder enable, active-low (0 only in IDLE)
//   min_tens..sec_ones  displayed BCD digits (registered)
//   running          1 while counting down
//   done             one-cycle pulse when the count reaches 00:00
module keypad_timer #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned PW       = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_bcd,
   input  logic       key_dv,
   input  logic       start,
   input  logic       cancel,
   input  logic       door_open,
   output logic       key_en_n,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t        state_q;
   logic [PW-1:0] pre_q;
   logic [3:0]    mt_q, mo_q, st_q, so_q;
   logic          kdv_q;
   logic          running_q;
   logic          done_q;
   logic          key_en_n_q;

   logic [3:0]    mt_d, mo_d, st_d, so_d;
   logic          press;
   logic          tick;
   logic          nonzero;
   logic          dec_zero;

   // A press is the falling edge of the active-low valid flag with a
   // legal decimal digit; holding the key does not repeat.
   assign press   = kdv_q & ~key_dv & (key_bcd <= 4'd9);
   assign tick    = (pre_q == PW'(TICK_DIV - 1));
   assign nonzero = |{mt_q, mo_q, st_q, so_q};

   // One-second decrement with per-digit borrow. Seconds above 59 are
   // counted down as entered; only an exhausted seconds field reloads 59.
   always_comb begin
      mt_d = mt_q;
      mo_d = mo_q;
      st_d = st_q;
      so_d = so_q;
      if (so_q != 4'd0) begin
         so_d = so_q - 4'd1;
      end else if (st_q != 4'd0) begin
         st_d = st_q - 4'd1;
         so_d = 4'd9;
      end else begin
         st_d = 4'd5;
         so_d = 4'd9;
         if (mo_q != 4'd0) begin
            mo_d = mo_q - 4'd1;
         end else begin
            mt_d = mt_q - 4'd1;
            mo_d = 4'd9;
         end
      end
   end

   assign dec_zero = ~|{mt_d, mo_d, st_d, so_d};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         mt_q       <= 4'd0;
         mo_q       <= 4'd0;
         st_q       <= 4'd0;
         so_q       <= 4'd0;
         kdv_q      <= 1'b0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         key_en_n_q <= 1'b0;
      end else begin
         kdv_q  <= key_dv;
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cancel) begin
                  mt_q <= 4'd0;
                  mo_q <= 4'd0;
                  st_q <= 4'd0;
                  so_q <= 4'd0;
               end else if (start && !door_open && nonzero) begin
                  // Any key press in this cycle is dropped.
                  state_q    <= RUN;
                  pre_q      <= '0;
                  running_q  <= 1'b1;
                  key_en_n_q <= 1'b1;
               end else if (press) begin
                  mt_q <= mo_q;
                  mo_q <= st_q;
                  st_q <= so_q;
                  so_q <= key_bcd;
               end
            end
            RUN: begin
               if (cancel || door_open) begin
                  // Prescaler is held so a resume finishes the
                  // partial second; a tick due now is lost.
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
               end else if (tick) begin
                  pre_q <= '0;
                  mt_q  <= mt_d;
                  mo_q  <= mo_d;
                  st_q  <= st_d;
                  so_q  <= so_d;
                  if (dec_zero) begin
                     state_q    <= IDLE;
                     running_q  <= 1'b0;
                     key_en_n_q <= 1'b0;
                     done_q     <= 1'b1;
                  end
               end else begin
                  pre_q <= pre_q + PW'(1);
               end
            end
            PAUSE: begin
               if (cancel) begin
                  state_q    <= IDLE;
                  key_en_n_q <= 1'b0;
                  mt_q       <= 4'd0;
                  mo_q       <= 4'd0;
                  st_q       <= 4'd0;
                  so_q       <= 4'd0;
               end else if (start && !door_open) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               running_q  <= 1'b0;
               key_en_n_q <= 1'b0;
            end
         endcase
      end
   end

   assign key_en_n = key_en_n_q;
   assign min_tens = mt_q;
   assign min_ones = mo_q;
   assign sec_tens = st_q;
   assign sec_ones = so_q;
   assign running  = running_q;
   assign done     = done_q;

endmodule

// File: tb/tb_keypad_timer.sv
// Self-checking bench for keypad_timer: directed scenarios plus a
// randomized run against a time-value reference model.
module tb_keypad_timer;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] kbcd = 4'd0;
   logic       kdv = 1'b1;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic       door = 1'b0;
   logic       key_en_n;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running;
   logic       done;

   int checks = 0;
   int failures = 0;

   // Reference model: time as a 4-digit decimal number MMSS,
   // mode 0 = idle, 1 = run, 2 = pause.
   int m_mode = 0;
   int m_val = 0;
   int m_pre = 0;
   bit m_kq = 1'b0;
   bit m_done = 1'b0;

   always #5 clk = ~clk;

   keypad_timer #(.TICK_DIV(TD), .PW(3)) dut (
      .clk(clk),
      .rst(rst),
      .key_bcd(kbcd),
      .key_dv(kdv),
      .start(start),
      .cancel(cancel),
      .door_open(door),
      .key_en_n(key_en_n),
      .min_tens(min_tens),
      .min_ones(min_ones),
      .sec_tens(sec_tens),
      .sec_ones(sec_ones),
      .running(running),
      .done(done)
   );

   wire [15:0] disp = {min_tens, min_ones, sec_tens, sec_ones};
   wire [18:0] obs  = {disp, running, done, key_en_n};

   function automatic int dec_time(int v);
      int m, s;
      m = v / 100;
      s = v % 100;
      if (s > 0) s = s - 1;
      else begin
         m = m - 1;
         s = 59;
      end
      return m * 100 + s;
   endfunction

   function automatic logic [18:0] exp_vec();
      logic [15:0] d;
      d = {4'(m_val / 1000), 4'((m_val / 100) % 10),
           4'((m_val / 10) % 10), 4'(m_val % 10)};
      return {d, m_mode == 1, m_done, m_mode != 0};
   endfunction

   task automatic model_update();
      bit pr;
      pr = m_kq && !kdv && (kbcd <= 4'd9);
      m_done = 1'b0;
      if (rst) begin
         m_mode = 0;
         m_val = 0;
         m_pre = 0;
         m_kq = 1'b0;
      end else begin
         case (m_mode)
            0: begin
               if (cancel) m_val = 0;
               else if (start && !door && m_val != 0) begin
                  m_mode = 1;
                  m_pre = 0;
               end else if (pr) m_val = (m_val * 10 + int'(kbcd)) % 10000;
            end
            1: begin
               if (cancel || door) m_mode = 2;
               else if (m_pre == TD - 1) begin
                  m_pre = 0;
                  m_val = dec_time(m_val);
                  if (m_val == 0) begin
                     m_mode = 0;
                     m_done = 1'b1;
                  end
               end else m_pre = m_pre + 1;
            end
            default: begin
               if (cancel) begin
                  m_val = 0;
                  m_mode = 0;
               end else if (start && !door) m_mode = 1;
            end
         endcase
         m_kq = kdv;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      kdv = 1'b1;
      start = 1'b0;
      cancel = 1'b0;
      door = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic press(input logic [3:0] d);
      kbcd = d;
      kdv = 1'b0;
      repeat (3) step();
      kdv = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs !== 19'h0) begin
         failures++;
         $display("FAIL reset_outputs got %h want 00000", obs);
      end
   endtask

   task automatic test_entry();
      do_reset();
      press(4'd1);
      press(4'd3);
      checks++;
      if (disp !== 16'h0013 || key_en_n !== 1'b0) begin
         failures++;
         $display("FAIL entry_13 got %h en_n=%b want 0013 en_n=0", disp, key_en_n);
      end
      press(4'd0);
      checks++;
      if (disp !== 16'h0130 || key_en_n !== 1'b0) begin
         failures++;
         $display("FAIL entry_130 got %h en_n=%b want 0130 en_n=0", disp, key_en_n);
      end
   endtask

   task automatic test_countdown();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (running !== 1'b1 || key_en_n !== 1'b1) begin
         failures++;
         $display("FAIL start_run got run=%b en_n=%b want 1 1", running, key_en_n);
      end
      repeat (4) step();
      checks++;
      if (disp !== 16'h0129) begin
         failures++;
         $display("FAIL first_tick got %h want 0129", disp);
      end
      repeat (116) step();
      checks++;
      if (disp !== 16'h0100) begin
         failures++;
         $display("FAIL reach_0100 got %h want 0100", disp);
      end
      repeat (4) step();
      checks++;
      if (disp !== 16'h0059) begin
         failures++;
         $display("FAIL borrow_0059 got %h want 0059", disp);
      end
      repeat (232) step();
      checks++;
      if (disp !== 16'h0001 || done !== 1'b0) begin
         failures++;
         $display("FAIL reach_0001 got %h done=%b want 0001 0", disp, done);
      end
      repeat (4) step();
      checks++;
      if (obs !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL expiry got %h want 00002", obs);
      end
      step();
      checks++;
      if (obs !== 19'h0) begin
         failures++;
         $display("FAIL done_one_cycle got %h want 00000", obs);
      end
   endtask

   task automatic test_pause();
      do_reset();
      press(4'd5);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      door = 1'b1;
      repeat (10) step();
      checks++;
      if (disp !== 16'h0005 || running !== 1'b0 || key_en_n !== 1'b1) begin
         failures++;
         $display("FAIL door_pause got %h run=%b en_n=%b want 0005 0 1",
                  disp, running, key_en_n);
      end
      door = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      checks++;
      if (disp !== 16'h0005 || running !== 1'b1) begin
         failures++;
         $display("FAIL resume_early got %h run=%b want 0005 1", disp, running);
      end
      step();
      checks++;
      if (disp !== 16'h0004) begin
         failures++;
         $display("FAIL resume_partial got %h want 0004", disp);
      end
   endtask

   task automatic test_ignore();
      do_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (running !== 1'b0 || key_en_n !== 1'b0) begin
         failures++;
         $display("FAIL start_zero got run=%b en_n=%b want 0 0", running, key_en_n);
      end
      kbcd = 4'hf;
      kdv = 1'b0;
      step();
      kdv = 1'b1;
      step();
      checks++;
      if (disp !== 16'h0000) begin
         failures++;
         $display("FAIL bad_code got %h want 0000", disp);
      end
      kbcd = 4'd7;
      kdv = 1'b0;
      repeat (20) step();
      kdv = 1'b1;
      step();
      checks++;
      if (disp !== 16'h0007) begin
         failures++;
         $display("FAIL held_key got %h want 0007", disp);
      end
      door = 1'b1;
      start = 1'b1;
      step();
      door = 1'b0;
      start = 1'b0;
      checks++;
      if (running !== 1'b0 || key_en_n !== 1'b0) begin
         failures++;
         $display("FAIL start_door got run=%b en_n=%b want 0 0", running, key_en_n);
      end
   endtask

   task automatic test_99_cancel();
      do_reset();
      press(4'd9);
      press(4'd9);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (395) step();
      checks++;
      if (disp !== 16'h0001 || done !== 1'b0) begin
         failures++;
         $display("FAIL n99_0001 got %h done=%b want 0001 0", disp, done);
      end
      step();
      checks++;
      if (disp !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
         failures++;
         $display("FAIL n99_expiry got %h done=%b run=%b want 0000 1 0",
                  disp, done, running);
      end
      press(4'd5);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      cancel = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      cancel = 1'b0;
      checks++;
      if (disp !== 16'h0005 || running !== 1'b0 || key_en_n !== 1'b1) begin
         failures++;
         $display("FAIL cancel_pause got %h run=%b en_n=%b want 0005 0 1",
                  disp, running, key_en_n);
      end
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++;
      if (obs !== 19'h0) begin
         failures++;
         $display("FAIL cancel_clear got %h want 00000", obs);
      end
   endtask

   task automatic test_rst_mid_run();
      do_reset();
      press(4'd1);
      press(4'd2);
      press(4'd3);
      press(4'd4);
      press(4'd5);
      checks++;
      if (disp !== 16'h2345) begin
         failures++;
         $display("FAIL fifth_digit got %h want 2345", disp);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (6) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (obs !== 19'h0) begin
         failures++;
         $display("FAIL rst_mid_run got %h want 00000", obs);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst    = ($urandom_range(0, 399) == 0);
         cancel = ($urandom_range(0, 59) == 0);
         door   = ($urandom_range(0, 24) == 0);
         start  = ($urandom_range(0, 7) == 0);
         kdv    = ($urandom_range(0, 2) != 0);
         kbcd   = 4'($urandom_range(0, 15));
         step();
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL random_%0d got %h want %h", i, obs, exp_vec());
         end
      end
      rst = 1'b0;
      cancel = 1'b0;
      door = 1'b0;
      start = 1'b0;
      kdv = 1'b1;
   endtask

   initial begin
      test_reset();
      test_entry();
      test_countdown();
      test_pause();
      test_ignore();
      test_99_cancel();
      test_rst_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_timer.md
Name: keypad_timer

Overview:
- Microwave cook-timer stage directly downstream of the keypad encoder. It consumes the encoder's BCD digit and its active-low valid flag.
- In entry mode, each new key press shifts one digit into a 4-digit MM:SS register.
- On start, the register counts down once per second. The block pauses on door-open or cancel and pulses done when the count reaches 00:00.
- It also drives the encoder's active-low enable, so keys are only accepted in entry mode.

Parameters:
- TICK_DIV, 50000000, clock cycles per one-second tick (benches use 4).
- PW, 26, prescaler width; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- key_bcd  input  4  BCD digit from the encoder.
- key_dv  input  1  encoder valid flag, active-low: 0 = valid digit on key_bcd, 1 = no/invalid key.
- start  input  1  start/resume request, level-sampled each cycle.
- cancel  input  1  pause when running; clear when paused or idle.
- door_open  input  1  1 = door open.
- key_en_n  output  1  encoder enable, active-low: 0 only in IDLE.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  displayed BCD digits (registered).
- running  output  1  1 in RUN (magnetron on).
- done  output  1  one-cycle pulse when the countdown expires.

Behaviour:
- Reset: state IDLE; all digits 0; running 0; done 0; key_en_n 0; prescaler 0; key_dv_q 0 (a key held through reset is not a press).
- key_dv_q is key_dv registered every cycle. A press is key_dv_q==1 && key_dv==0 && key_bcd<=9. Codes 10..15 are ignored.
- States: IDLE, RUN, PAUSE. Outputs: running = (state==RUN); key_en_n = (state!=IDLE). Both are registered alongside state.
- Priority each cycle: cancel > door_open > start > tick/press.
- IDLE, press:
  - Shift left at the detecting edge (1-cycle latency): min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_bcd.
  - A fifth digit drops the old min_tens.
- IDLE, cancel: clear all digits to 0, stay IDLE.
- IDLE, start with door closed and any digit nonzero: go to RUN, prescaler<=0. A press in the same cycle is discarded.
- IDLE, start with time 00:00 or door open: ignored.
- RUN, prescaler: counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the time decrements by one second.
- RUN, decrement rules:
  - If sec_ones>0: sec_ones-1.
  - Else if sec_tens>0: sec_tens-1, sec_ones<=9.
  - Else borrow from minutes: sec_tens<=5, sec_ones<=9. If min_ones>0, min_ones-1; else min_tens-1, min_ones<=9.
  - Entered seconds >59 (e.g. 00:99) are counted as entered; there is no normalisation.
- RUN, expiry: a tick whose result is 00:00 moves the block to IDLE, with running 0 and done=1 for exactly the following cycle. Digits remain 00:00.
- RUN, door_open or cancel: go to PAUSE with the prescaler held. Any tick due in that same cycle is suppressed (no decrement).
- PAUSE:
  - start with door closed: return to RUN; the prescaler resumes from its held value.
  - cancel: clear digits, go to IDLE.
  - Key presses are ignored.
- done is never asserted outside the expiry cycle. rst in any state returns everything to reset values at the next edge.

Test Plan:
- Reset, then presses 1,3,0, each held 3 cycles with key_dv=1 between: display 00:13 after the second press, 01:30 after the third; key_en_n=0 throughout.
- TICK_DIV=4, time 01:30, start: running=1 next cycle; 01:29 after 4 cycles; 01:00 is followed by 00:59; 00:01 is followed by 00:00 with done high for exactly one cycle, running=0, state IDLE.
- Time 00:05, running, door_open asserted for 10 cycles mid-prescaler: digits frozen, running=0, key_en_n=1; on door close + start, the next tick arrives after the remaining prescaler count, not a full period.
- Time 00:00 with start: no state change. key_bcd=4'b1111 with key_dv=0: ignored. Key held low for 20 cycles: exactly one shift.
- Entry 9,9 (00:99), start, TICK_DIV=4: reaches 00:00 after 99 ticks (396 cycles); cancel+start asserted in the same cycle while running leads to PAUSE; cancel again clears to 00:00 in IDLE.
- Presses 1,2,3,4,5: display 23:45. rst asserted mid-RUN: all outputs at reset values the next cycle.
